// File: rtl/spi_reg_ctrl.sv
// rtl/spi_reg_ctrl.sv - SPI byte command controller driving a 128-entry register bus
//
// Purpose:
//   Splits each CS-framed SPI transaction into a command byte and data bytes.
//   Command bit7=1 starts an auto-incrementing write burst, bit7=0 a read burst.
//   Read data, or a status byte on return to idle, is handed to the SPI
//   peripheral through o_TX_DV / o_TX_Byte.
//
// Ports:
//   i_Clk, i_Rst_L              fabric clock, asynchronous active-low reset
//   i_SPI_CS_n                  raw chip select (asynchronous, active low)
//   i_RX_DV, i_RX_Byte          received byte strobe and data
//   o_TX_DV, o_TX_Byte          load strobe and byte for the peripheral
//   o_Reg_Addr                  register address (held between strobes)
//   o_Reg_Wr_En, o_Reg_Wr_Data  write strobe and data
//   o_Reg_Rd_En, i_Reg_Rd_Data  read strobe, data valid RD_LATENCY cycles later
//   o_Busy                      frame active
//   o_Frame_Done                one-cycle pulse at frame end
//   o_Frame_Len                 saturating byte count of last/current frame
//   o_Overrun                   sticky: byte arrived while a read was in flight

`timescale 1ns/1ps

module spi_reg_ctrl #(
  parameter int          RD_LATENCY  = 1,
  parameter logic [7:0]  STATUS_BYTE = 8'hA4
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_SPI_CS_n,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  output logic       o_TX_DV,
  output logic [7:0] o_TX_Byte,
  output logic [6:0] o_Reg_Addr,
  output logic       o_Reg_Wr_En,
  output logic [7:0] o_Reg_Wr_Data,
  output logic       o_Reg_Rd_En,
  input  logic [7:0] i_Reg_Rd_Data,
  output logic       o_Busy,
  output logic       o_Frame_Done,
  output logic [7:0] o_Frame_Len,
  output logic       o_Overrun
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WR,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_RD_HOLD
  } state_t;

  localparam logic [2:0] LAT = 3'(RD_LATENCY);

  state_t     state_q, state_d;
  logic       cs_meta_q, cs_meta_d;
  logic       cs_sync_q, cs_sync_d;
  logic       cs_prev_q, cs_prev_d;
  logic [1:0] sync_vld_q, sync_vld_d;
  logic       status_init_q, status_init_d;
  logic [6:0] addr_q, addr_d;
  logic [6:0] reg_addr_q, reg_addr_d;
  logic       wr_en_q, wr_en_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       rd_en_q, rd_en_d;
  logic       tx_dv_q, tx_dv_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic       frame_done_q, frame_done_d;
  logic [7:0] frame_len_q, frame_len_d;
  logic       overrun_q, overrun_d;
  logic [2:0] rd_cnt_q, rd_cnt_d;

  logic       cs_fall;
  logic       cs_rise;

  // cs_prev only tracks the synchronized CS once the synchronizer holds a real
  // sample. Until then it reads 0, so a CS already low at reset release never
  // looks like a falling edge; CS must be seen high first.
  assign cs_fall = cs_prev_q & ~cs_sync_q;
  assign cs_rise = sync_vld_q[1] & ~cs_prev_q & cs_sync_q;

  always_comb begin
    state_d       = state_q;
    cs_meta_d     = i_SPI_CS_n;
    cs_sync_d     = cs_meta_q;
    cs_prev_d     = cs_sync_q & sync_vld_q[1];
    sync_vld_d    = {sync_vld_q[0], 1'b1};
    status_init_d = 1'b0;
    addr_d        = addr_q;
    reg_addr_d    = reg_addr_q;
    wr_en_d       = 1'b0;
    wr_data_d     = wr_data_q;
    rd_en_d       = 1'b0;
    tx_dv_d       = 1'b0;
    tx_byte_d     = tx_byte_q;
    frame_done_d  = 1'b0;
    frame_len_d   = frame_len_q;
    overrun_d     = overrun_q;
    rd_cnt_d      = rd_cnt_q;

    if (i_RX_DV && (state_q != ST_IDLE) && (frame_len_q != 8'hFF)) begin
      frame_len_d = frame_len_q + 8'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d     = ST_CMD;
          frame_len_d = 8'd0;
          overrun_d   = 1'b0;
        end
      end
      ST_CMD: begin
        if (i_RX_DV) begin
          addr_d  = i_RX_Byte[6:0];
          state_d = i_RX_Byte[7] ? ST_WR : ST_RD_ISSUE;
        end
      end
      ST_WR: begin
        if (i_RX_DV) begin
          wr_en_d    = 1'b1;
          wr_data_d  = i_RX_Byte;
          reg_addr_d = addr_q;
          addr_d     = addr_q + 7'd1;
        end
      end
      ST_RD_ISSUE: begin
        rd_en_d    = 1'b1;
        reg_addr_d = addr_q;
        rd_cnt_d   = 3'd0;
        state_d    = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        // Counter is 0 in the cycle the read strobe is on the bus, so the
        // data is sampled exactly LAT cycles after the strobe.
        if (i_RX_DV) begin
          overrun_d = 1'b1;
        end
        if (rd_cnt_q == LAT) begin
          tx_dv_d   = 1'b1;
          tx_byte_d = i_Reg_Rd_Data;
          state_d   = ST_RD_HOLD;
        end else begin
          rd_cnt_d = rd_cnt_q + 3'd1;
        end
      end
      ST_RD_HOLD: begin
        if (i_RX_DV) begin
          addr_d  = addr_q + 7'd1;
          state_d = ST_RD_ISSUE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Frame end wins over everything: no new strobes or read-data loads are
    // started, and the bus outputs keep their previous values.
    if (cs_rise && (state_q != ST_IDLE)) begin
      state_d      = ST_IDLE;
      frame_done_d = 1'b1;
      wr_en_d      = 1'b0;
      rd_en_d      = 1'b0;
      tx_dv_d      = 1'b0;
      wr_data_d    = wr_data_q;
      reg_addr_d   = reg_addr_q;
      tx_byte_d    = tx_byte_q;
    end

    // Status load on every IDLE entry, including the first cycle out of reset.
    if (status_init_q || ((state_d == ST_IDLE) && (state_q != ST_IDLE))) begin
      tx_dv_d   = 1'b1;
      tx_byte_d = {STATUS_BYTE[7:1], overrun_d};
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q       <= ST_IDLE;
      cs_meta_q     <= 1'b1;
      cs_sync_q     <= 1'b1;
      cs_prev_q     <= 1'b0;
      sync_vld_q    <= 2'b00;
      status_init_q <= 1'b1;
      addr_q        <= 7'd0;
      reg_addr_q    <= 7'd0;
      wr_en_q       <= 1'b0;
      wr_data_q     <= 8'd0;
      rd_en_q       <= 1'b0;
      tx_dv_q       <= 1'b0;
      tx_byte_q     <= 8'd0;
      frame_done_q  <= 1'b0;
      frame_len_q   <= 8'd0;
      overrun_q     <= 1'b0;
      rd_cnt_q      <= 3'd0;
    end else begin
      state_q       <= state_d;
      cs_meta_q     <= cs_meta_d;
      cs_sync_q     <= cs_sync_d;
      cs_prev_q     <= cs_prev_d;
      sync_vld_q    <= sync_vld_d;
      status_init_q <= status_init_d;
      addr_q        <= addr_d;
      reg_addr_q    <= reg_addr_d;
      wr_en_q       <= wr_en_d;
      wr_data_q     <= wr_data_d;
      rd_en_q       <= rd_en_d;
      tx_dv_q       <= tx_dv_d;
      tx_byte_q     <= tx_byte_d;
      frame_done_q  <= frame_done_d;
      frame_len_q   <= frame_len_d;
      overrun_q     <= overrun_d;
      rd_cnt_q      <= rd_cnt_d;
    end
  end

  assign o_TX_DV       = tx_dv_q;
  assign o_TX_Byte     = tx_byte_q;
  assign o_Reg_Addr    = reg_addr_q;
  assign o_Reg_Wr_En   = wr_en_q;
  assign o_Reg_Wr_Data = wr_data_q;
  assign o_Reg_Rd_En   = rd_en_q;
  assign o_Busy        = (state_q != ST_IDLE);
  assign o_Frame_Done  = frame_done_q;
  assign o_Frame_Len   = frame_len_q;
  assign o_Overrun     = overrun_q;

endmodule
